proc_sequencer: RTL and testbench



---
 rtl/proc_sequencer_pkg.sv | 48 ++++
 rtl/proc_sequencer_if.sv | 29 ++
 rtl/proc_seq_mem.sv | 33 +++
 rtl/proc_sequencer.sv | 151 +++++++++++++++
 tb/tb_proc_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_sequencer_pkg.sv
// rtl/proc_sequencer_pkg.sv - shared states, instruction field layout and opcodes for the program sequencer
//
// Purpose: common definitions imported by the sequencer top and its bench.
//   state_t      : sequencer FSM states
//   instr_t      : decoded instruction fields driven to the processor
//   decode_word  : splits a 16-bit program word into instr_t
package proc_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FIN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Program word layout: {F, Rx, Ry, rsvd[1:0], Data}
    localparam int F_HI    = 15;
    localparam int F_LO    = 14;
    localparam int RX_HI   = 13;
    localparam int RX_LO   = 12;
    localparam int RY_HI   = 11;
    localparam int RY_LO   = 10;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_MOVE = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

    typedef struct packed {
        logic [1:0] f;
        logic [1:0] rx;
        logic [1:0] ry;
        logic [7:0] data;
    } instr_t;

    function automatic instr_t decode_word(input logic [15:0] word);
        instr_t ins;
        ins.f    = word[F_HI:F_LO];
        ins.rx   = word[RX_HI:RX_LO];
        ins.ry   = word[RY_HI:RY_LO];
        ins.data = word[DATA_HI:DATA_LO];
        return ins;
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// rtl/proc_sequencer_if.sv - instruction/Done handshake between sequencer and bus processor
//
// Purpose: bundles the processor instruction interface.
//   w         : one-cycle instruction-valid pulse (master -> slave)
//   f, rx, ry : opcode and register fields      (master -> slave)
//   data      : 8-bit immediate for load         (master -> slave)
//   done      : processor Done                   (slave -> master)
//   bus       : processor BusWires               (slave -> master)
interface proc_sequencer_if;

    logic       w;
    logic [1:0] f;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [7:0] data;
    logic       done;
    logic [7:0] bus;

    modport master (
        output w, f, rx, ry, data,
        input  done, bus
    );

    modport slave (
        input  w, f, rx, ry, data,
        output done, bus
    );

endinterface

// File: rtl/proc_seq_mem.sv
// rtl/proc_seq_mem.sv - DEPTH x 16 program memory, synchronous write, asynchronous read
//
// Ports:
//   i_clk      : rising-edge clock
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write word
//   i_rd_addr  : read address
//   o_rd_data  : combinational read of mem[i_rd_addr] (pre-write value on a same-cycle write)
module proc_seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data
);

    // Contents are intentionally not reset.
    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - program sequencer issuing instructions to the bus processor
//
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_load_en     : write i_load_word to mem[i_load_addr] (ignored while busy)
//   i_load_addr   : program memory write address
//   i_load_word   : {F, Rx, Ry, rsvd, Data}
//   i_start       : run program from address 0 (ignored while busy)
//   i_length      : instruction count sampled on accepted start, clamped to DEPTH
//   proc          : instruction/Done handshake to the processor (master side)
//   o_busy        : high in ISSUE/WAIT
//   o_finished    : one-cycle pulse when the program completes
//   o_error       : sticky Done-timeout flag, cleared by the next accepted start
//   o_pc          : index of current/next instruction
//   o_last_bus    : processor bus captured on the last accepted Done
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load_en,
    input  logic [AW-1:0]           i_load_addr,
    input  logic [15:0]             i_load_word,
    input  logic                    i_start,
    input  logic [AW:0]             i_length,
    proc_sequencer_if.master        proc,
    output logic                    o_busy,
    output logic                    o_finished,
    output logic                    o_error,
    output logic [AW-1:0]           o_pc,
    output logic [7:0]              o_last_bus
);

    localparam logic [AW:0] LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [7:0]  LP_TO_LAST = 8'(TIMEOUT - 1);

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic [AW:0]     r_remaining;
    logic [7:0]      r_wait_cnt;
    instr_t          r_instr;
    logic [7:0]      r_last_bus;
    logic            r_error;

    logic            w_busy;
    logic            w_start_ok;
    logic            w_mem_we;
    logic [AW-1:0]   w_rd_addr;
    logic [15:0]     w_rd_word;
    instr_t          w_rd_instr;
    logic [AW:0]     w_len;
    logic            w_unused_rsvd;

    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_mem_we   = i_load_en && !w_busy;

    // Only two fetch points exist: address 0 on start, PC+1 on Done in WAIT.
    assign w_rd_addr  = (r_state == S_WAIT) ? (r_pc + AW'(1)) : '0;
    assign w_len      = (i_length > LP_DEPTH) ? LP_DEPTH : i_length;

    assign w_rd_instr    = decode_word(w_rd_word);
    assign w_unused_rsvd = ^w_rd_word[9:8];

    proc_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (i_load_addr),
        .i_wr_data (i_load_word),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_remaining <= '0;
            r_wait_cnt  <= '0;
            r_instr     <= '0;
            r_last_bus  <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (w_start_ok) begin
                        r_pc    <= '0;
                        r_error <= 1'b0;
                        if (w_len == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_remaining <= w_len;
                            r_instr     <= w_rd_instr;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (proc.done) begin
                        r_last_bus  <= proc.bus;
                        r_remaining <= r_remaining - (AW+1)'(1);
                        if (r_remaining == (AW+1)'(1)) begin
                            r_state <= S_FIN;
                        end else begin
                            r_pc    <= r_pc + AW'(1);
                            r_instr <= w_rd_instr;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_wait_cnt == LP_TO_LAST) begin
                        // This edge completes TIMEOUT Done-less WAIT cycles.
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // w and busy decode from the state register, so reset drops them at once.
    assign proc.w    = (r_state == S_ISSUE);
    assign proc.f    = r_instr.f;
    assign proc.rx   = r_instr.rx;
    assign proc.ry   = r_instr.ry;
    assign proc.data = r_instr.data;

    assign o_busy     = w_busy;
    assign o_finished = (r_state == S_FIN);
    assign o_error    = r_error;
    assign o_pc       = r_pc;
    assign o_last_bus = r_last_bus;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - directed bench for proc_sequencer with a behavioural bus processor
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_word;
    logic          start;
    logic [AW:0]   length;
    logic          busy;
    logic          finished;
    logic          error;
    logic [AW-1:0] pc;
    logic [7:0]    last_bus;

    int vectors     = 0;
    int miscompares = 0;

    proc_sequencer_if pif ();

    proc_sequencer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load_en   (load_en),
        .i_load_addr (load_addr),
        .i_load_word (load_word),
        .i_start     (start),
        .i_length    (length),
        .proc        (pif.master),
        .o_busy      (busy),
        .o_finished  (finished),
        .o_error     (error),
        .o_pc        (pc),
        .o_last_bus  (last_bus)
    );

    always #5 clk = ~clk;

    // Behavioural processor: load/move finish in T1, add/sub in T3.
    logic       proc_en;
    logic [1:0] p_step;
    logic [1:0] p_op;
    logic [1:0] p_rx;
    logic [1:0] p_ry;
    logic [7:0] p_data;
    logic [7:0] p_r [4];
    logic [7:0] p_bus;

    always_comb begin
        p_bus = 8'h00;
        case (p_op)
            OP_LOAD: p_bus = p_data;
            OP_MOVE: p_bus = p_r[p_ry];
            OP_ADD:  p_bus = p_r[p_rx] + p_r[p_ry];
            default: p_bus = p_r[p_rx] - p_r[p_ry];
        endcase
    end

    assign pif.bus  = p_bus;
    assign pif.done = (p_step == 2'd1 && !p_op[1]) || (p_step == 2'd3 && p_op[1]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_step <= 2'd0;
            p_op   <= 2'd0;
            p_rx   <= 2'd0;
            p_ry   <= 2'd0;
            p_data <= 8'h00;
        end else if (p_step == 2'd0) begin
            if (pif.w && proc_en) begin
                p_step <= 2'd1;
                p_op   <= pif.f;
                p_rx   <= pif.rx;
                p_ry   <= pif.ry;
                p_data <= pif.data;
            end
        end else if (pif.done) begin
            p_r[p_rx] <= p_bus;
            p_step    <= 2'd0;
        end else begin
            p_step <= p_step + 2'd1;
        end
    end

    // Scenario results
    logic [15:0] wmask;
    int          fin_c;
    int          err_c;
    logic [1:0]  lw_f;
    logic [1:0]  lw_rx;
    logic [1:0]  lw_ry;
    logic [7:0]  w0_data;

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_word = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic load_add_prog(input logic [15:0] third);
        load(4'd0, 16'h0005);
        load(4'd1, 16'h1003);
        load(4'd2, third);
    endtask

    // c = number of edges after the start edge; mode 1 pokes start/load while
    // busy, mode 2 returns early in the WAIT of the 2nd instruction.
    task automatic run(input logic [AW:0] len, input int mode);
        bit seen_w;
        seen_w = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        length = len;
        @(posedge clk);
        #1 start = 1'b0;
        wmask = '0;
        fin_c = -1;
        err_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pif.w) begin
                if (c < 16) wmask[c] = 1'b1;
                if (!seen_w) w0_data = pif.data;
                seen_w = 1'b1;
                lw_f  = pif.f;
                lw_rx = pif.rx;
                lw_ry = pif.ry;
            end
            if (mode == 1 && c == 1) begin
                start = 1'b1; length = 5'd1;
                load_en = 1'b1; load_addr = 4'd0; load_word = 16'hFFFF;
            end else if (mode == 1 && c == 2) begin
                start = 1'b0; load_en = 1'b0;
            end
            if (finished && fin_c < 0) fin_c = c;
            if (error && err_c < 0) err_c = c;
            if (fin_c >= 0 || err_c >= 0) break;
            if (mode == 2 && c == 3) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (pif.w !== 1'b0) begin miscompares++; $display("FAIL reset_w: got %0b expected 0", pif.w); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished: got %0b expected 0", finished); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0b expected 0", error); end
        vectors++; if (pc !== 4'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        vectors++; if (last_bus !== 8'h00) begin miscompares++; $display("FAIL reset_last_bus: got %0h expected 0", last_bus); end
        vectors++; if ({pif.f, pif.rx, pif.ry, pif.data} !== 14'h0) begin miscompares++; $display("FAIL reset_fields: got %0h expected 0", {pif.f, pif.rx, pif.ry, pif.data}); end
        rst = 1'b0;
    endtask

    task automatic test_add_program;
        load_add_prog(16'h8400);
        run(5'd3, 0);
        vectors++; if (wmask !== 16'h0015) begin miscompares++; $display("FAIL add_w_cycles: got %0h expected 15", wmask); end
        vectors++; if (fin_c !== 8) begin miscompares++; $display("FAIL add_finished_cycle: got %0d expected 8", fin_c); end
        vectors++; if (last_bus !== 8'h08) begin miscompares++; $display("FAIL add_last_bus: got %0h expected 08", last_bus); end
        vectors++; if (w0_data !== 8'h05) begin miscompares++; $display("FAIL add_first_data: got %0h expected 05", w0_data); end
        vectors++; if ({lw_f, lw_rx, lw_ry} !== {2'd2, 2'd0, 2'd1}) begin miscompares++; $display("FAIL add_last_fields: got %0h expected 21", {lw_f, lw_rx, lw_ry}); end
        vectors++; if (pc !== 4'd2) begin miscompares++; $display("FAIL add_pc: got %0d expected 2", pc); end
        @(negedge clk);
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL add_finished_pulse: got %0b expected 0", finished); end
    endtask

    task automatic test_sub_program;
        load_add_prog(16'hC400);
        run(5'd3, 0);
        vectors++; if (last_bus !== 8'h02) begin miscompares++; $display("FAIL sub_last_bus: got %0h expected 02", last_bus); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL sub_error: got %0b expected 0", error); end
        vectors++; if (fin_c !== 8) begin miscompares++; $display("FAIL sub_finished_cycle: got %0d expected 8", fin_c); end
    endtask

    task automatic test_length_zero;
        run(5'd0, 0);
        vectors++; if (fin_c !== 0) begin miscompares++; $display("FAIL len0_finished_cycle: got %0d expected 0", fin_c); end
        vectors++; if (wmask !== 16'h0000) begin miscompares++; $display("FAIL len0_w: got %0h expected 0", wmask); end
        vectors++; if (pc !== 4'd0) begin miscompares++; $display("FAIL len0_pc: got %0d expected 0", pc); end
    endtask

    task automatic test_timeout;
        proc_en = 1'b0;
        run(5'd1, 0);
        vectors++; if (wmask !== 16'h0001) begin miscompares++; $display("FAIL to_w: got %0h expected 1", wmask); end
        vectors++; if (err_c !== 9) begin miscompares++; $display("FAIL to_error_cycle: got %0d expected 9", err_c); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %0b expected 0", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %0b expected 1", error); end
        proc_en = 1'b1;
        run(5'd1, 0);
        vectors++; if (err_c !== -1) begin miscompares++; $display("FAIL to_restart_error: got %0d expected -1", err_c); end
        vectors++; if (fin_c !== 2) begin miscompares++; $display("FAIL to_restart_finished: got %0d expected 2", fin_c); end
        vectors++; if (last_bus !== 8'h05) begin miscompares++; $display("FAIL to_restart_bus: got %0h expected 05", last_bus); end
    endtask

    task automatic test_busy_ignore;
        load(4'd2, 16'h8400);
        run(5'd3, 1);
        vectors++; if (wmask !== 16'h0015) begin miscompares++; $display("FAIL busy_w_cycles: got %0h expected 15", wmask); end
        vectors++; if (fin_c !== 8) begin miscompares++; $display("FAIL busy_finished_cycle: got %0d expected 8", fin_c); end
        vectors++; if (last_bus !== 8'h08) begin miscompares++; $display("FAIL busy_last_bus: got %0h expected 08", last_bus); end
        run(5'd1, 0);
        vectors++; if (last_bus !== 8'h05) begin miscompares++; $display("FAIL busy_mem0_kept: got %0h expected 05", last_bus); end
    endtask

    task automatic test_reset_mid_wait;
        run(5'd3, 2);
        vectors++; if (busy !== 1'b1 || pc !== 4'd1) begin miscompares++; $display("FAIL mid_pre_state: got busy=%0b pc=%0d expected busy=1 pc=1", busy, pc); end
        vectors++; if (last_bus !== 8'h05) begin miscompares++; $display("FAIL mid_pre_bus: got %0h expected 05", last_bus); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (pif.w !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_w_busy: got w=%0b busy=%0b expected 0 0", pif.w, busy); end
        vectors++; if (pc !== 4'd0 || last_bus !== 8'h00) begin miscompares++; $display("FAIL mid_rst_pc_bus: got pc=%0d bus=%0h expected 0 0", pc, last_bus); end
        @(negedge clk);
        rst = 1'b0;
        run(5'd3, 0);
        vectors++; if (wmask !== 16'h0015 || fin_c !== 8) begin miscompares++; $display("FAIL mid_rerun_timing: got w=%0h fin=%0d expected 15 8", wmask, fin_c); end
        vectors++; if (last_bus !== 8'h08) begin miscompares++; $display("FAIL mid_rerun_bus: got %0h expected 08", last_bus); end
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_word = '0;
        start     = 1'b0;
        length    = '0;
        proc_en   = 1'b1;
        test_reset();
        test_add_program();
        test_sub_program();
        test_length_zero();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
